// File: rtl/risc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-register, 4-bit RISC datapath.
// Fetches 1- or 2-byte instructions over a req/ack port and drives ALU controls and register writes.
module risc_control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [2:0]      alu_op,
    output logic [1:0]      rd_sel,
    output logic [1:0]      rs_sel,
    output logic [3:0]      imm,
    output logic            reg_we,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ins_out,
    output logic            halted,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t state, state_next;

    logic [7:0] ir;
    logic [7:0] byte2;
    logic       z_flag;
    logic [3:0] op;
    logic       is_alu;
    logic       is_ldi;
    logic       writes_reg;

    assign op         = ir[7:4];
    assign is_alu     = (op >= 4'h1) && (op <= 4'h7);
    assign is_ldi     = (op == 4'h8);
    assign writes_reg = is_alu || is_ldi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // imem_req comes straight from the state register so reset removes it at once.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        reg_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    4'h8, 4'h9, 4'hA: state_next = S_FETCH2;
                    4'hF:             state_next = S_HALT;
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7: state_next = S_EXECUTE;
                    default:          state_next = S_FETCH;
                endcase
            end
            S_FETCH2: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                reg_we     = writes_reg;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            ir     <= 8'h00;
            byte2  <= 8'h00;
            z_flag <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_FETCH2: begin
                    if (imem_ack) begin
                        byte2 <= imem_data;
                        pc    <= pc + PC_W'(1);
                    end
                end
                S_EXECUTE: begin
                    if (writes_reg) z_flag <= alu_zero;
                    if (op == 4'h9) pc <= byte2[PC_W-1:0];
                    if ((op == 4'hA) && z_flag) pc <= byte2[PC_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Operand fields decode continuously from IR/byte2; they hold steady until the next fetch.
    always_comb begin
        alu_op = 3'b000;
        if (is_alu) begin
            alu_op = op[2:0] - 3'd1;
        end else if (is_ldi) begin
            alu_op = 3'b111;
        end
    end

    assign rd_sel    = ir[3:2];
    assign rs_sel    = ir[1:0];
    assign imm       = byte2[3:0];
    assign imem_addr = pc;
    assign ins_out   = ir;
    assign halted    = (state == S_HALT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_risc_control_unit.sv
// Self-checking bench for risc_control_unit: decode vector table, scoreboarded register writes,
// memory wait states, conditional jumps, PC wrap on a 4-bit PC, and mid-handshake reset.
module tb_risc_control_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [2:0] alu_op;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [3:0] imm;
    logic       reg_we;
    logic       alu_zero;
    logic [7:0] pc;
    logic [7:0] ins_out;
    logic       halted;
    logic       busy;

    logic       start4;
    logic       req4;
    logic [3:0] addr4;
    logic       ack4;
    logic [7:0] data4;
    logic [2:0] alu_op4;
    logic [1:0] rd_sel4;
    logic [1:0] rs_sel4;
    logic [3:0] imm4;
    logic       reg_we4;
    logic [3:0] pc4;
    logic [7:0] ins_out4;
    logic       halted4;
    logic       busy4;

    risc_control_unit #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_op(alu_op), .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm), .reg_we(reg_we),
        .alu_zero(alu_zero), .pc(pc), .ins_out(ins_out), .halted(halted), .busy(busy)
    );

    risc_control_unit #(.PC_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4), .imem_data(data4),
        .alu_op(alu_op4), .rd_sel(rd_sel4), .rs_sel(rs_sel4), .imm(imm4), .reg_we(reg_we4),
        .alu_zero(1'b0), .pc(pc4), .ins_out(ins_out4), .halted(halted4), .busy(busy4)
    );

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] imm;
        int         cyc;
    } we_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         we;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] imm;
        int         we_cyc;
        int         halt_cyc;
        logic [7:0] halt_pc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   mem_wait = 0;
    int   wait_cnt = 0;
    we_t  exp_q[$];
    we_t  exp_e;
    vec_t vecs[10];
    logic [7:0] mem8[256];
    logic [7:0] mem4[16];
    bit   req_pending = 0;
    bit   req_acked   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after mem_wait cycles of request, zero wait means same-cycle ack.
    assign imem_ack  = imem_req && (wait_cnt >= mem_wait);
    assign imem_data = mem8[imem_addr];
    assign ack4      = req4;
    assign data4     = mem4[addr4];

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Scoreboard pop on every write strobe, plus handshake shape checks.
    always @(negedge clk) begin
        if (rst) begin
            req_pending = 0;
            req_acked   = 0;
        end else begin
            if (reg_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("we_unexpected", {31'd0, reg_we}, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkOutput("we_alu_op", {29'd0, alu_op}, {29'd0, exp_e.op});
                    checkOutput("we_rd_sel", {30'd0, rd_sel}, {30'd0, exp_e.rd});
                    checkOutput("we_rs_sel", {30'd0, rs_sel}, {30'd0, exp_e.rs});
                    checkOutput("we_imm", {28'd0, imm}, {28'd0, exp_e.imm});
                    checkOutput("we_cycle", cyc - t0 + 1, exp_e.cyc);
                end
            end
            if (req_pending) checkOutput("req_held", {31'd0, imem_req}, 32'd1);
            if (req_acked)   checkOutput("req_drop", {31'd0, imem_req}, 32'd0);
            if (imem_req)    checkOutput("req_addr", {24'd0, imem_addr}, {24'd0, pc});
            req_pending = imem_req && !imem_ack;
            req_acked   = imem_req && imem_ack;
        end
    end

    task automatic doReset();
        start    = 1'b0;
        start4   = 1'b0;
        alu_zero = 1'b0;
        mem_wait = 0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic loadMem(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 256; i++) mem8[i] = 8'hF0;
        mem8[0] = b0;
        mem8[1] = b1;
        mem8[2] = b2;
        mem8[3] = b3;
    endtask

    task automatic applyStimulus(input bit use4, input bit hold);
        @(posedge clk);
        #1;
        if (use4) start4 = 1'b1;
        else      start  = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) begin
            start  = 1'b0;
            start4 = 1'b0;
        end
    endtask

    task automatic waitCycle(input int n);
        do @(negedge clk); while (cyc - t0 + 1 < n);
    endtask

    task automatic waitHalt(output int rel);
        bit seen;
        seen = 0;
        rel  = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (halted) begin
                seen = 1;
                rel  = cyc - t0 + 1;
            end
        end
        if (!seen) checkOutput("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    task automatic checkReset();
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_ins", {24'd0, ins_out}, 32'd0);
        checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
        checkOutput("rst_rd_sel", {30'd0, rd_sel}, 32'd0);
        checkOutput("rst_rs_sel", {30'd0, rs_sel}, 32'd0);
        checkOutput("rst_imm", {28'd0, imm}, 32'd0);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_we", {31'd0, reg_we}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_pc4", {28'd0, pc4}, 32'd0);
    endtask

    task automatic runMain(input int w);
        int rel;
        doReset();
        loadMem(8'h81, 8'h03, 8'h16, 8'hF0);
        mem_wait = w;
        exp_q.push_back(we_t'{3'b111, 2'd0, 2'd1, 4'd3, 4 + 2 * w});
        exp_q.push_back(we_t'{3'b000, 2'd1, 2'd2, 4'd3, 7 + 3 * w});
        applyStimulus(1'b0, 1'b0);
        waitHalt(rel);
        checkOutput($sformatf("main_w%0d_halt_cyc", w), rel, 10 + 4 * w);
        checkOutput($sformatf("main_w%0d_pc", w), {24'd0, pc}, 32'd4);
        checkOutput($sformatf("main_w%0d_ins", w), {24'd0, ins_out}, 32'hF0);
        checkOutput($sformatf("main_w%0d_busy", w), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("main_w%0d_q_empty", w), exp_q.size(), 32'd0);
    endtask

    task automatic runJz(input bit zval);
        int rel;
        doReset();
        loadMem(8'h20, 8'hA0, 8'h10, 8'hF0);
        alu_zero = zval;
        exp_q.push_back(we_t'{3'b001, 2'd0, 2'd0, 4'd0, 3});
        applyStimulus(1'b0, 1'b0);
        waitCycle(8);
        checkOutput($sformatf("jz_z%0d_pc_after_exec", zval), {24'd0, pc}, zval ? 32'h10 : 32'h3);
        waitHalt(rel);
        checkOutput($sformatf("jz_z%0d_halt_cyc", zval), rel, 32'd10);
        checkOutput($sformatf("jz_z%0d_halt_pc", zval), {24'd0, pc}, zval ? 32'h11 : 32'h4);
        checkOutput($sformatf("jz_z%0d_q_empty", zval), exp_q.size(), 32'd0);
    endtask

    initial begin
        int rel;

        vecs[0] = '{8'h1B, 8'hF0, 1'b1, 3'd0, 2'd2, 2'd3, 4'd0, 3, 6, 8'd2};
        vecs[1] = '{8'h24, 8'hF0, 1'b1, 3'd1, 2'd1, 2'd0, 4'd0, 3, 6, 8'd2};
        vecs[2] = '{8'h3E, 8'hF0, 1'b1, 3'd2, 2'd3, 2'd2, 4'd0, 3, 6, 8'd2};
        vecs[3] = '{8'h45, 8'hF0, 1'b1, 3'd3, 2'd1, 2'd1, 4'd0, 3, 6, 8'd2};
        vecs[4] = '{8'h5A, 8'hF0, 1'b1, 3'd4, 2'd2, 2'd2, 4'd0, 3, 6, 8'd2};
        vecs[5] = '{8'h6C, 8'hF0, 1'b1, 3'd5, 2'd3, 2'd0, 4'd0, 3, 6, 8'd2};
        vecs[6] = '{8'h79, 8'hF0, 1'b1, 3'd6, 2'd2, 2'd1, 4'd0, 3, 6, 8'd2};
        vecs[7] = '{8'h8D, 8'h0A, 1'b1, 3'd7, 2'd3, 2'd1, 4'hA, 4, 7, 8'd3};
        vecs[8] = '{8'h00, 8'hF0, 1'b0, 3'd0, 2'd0, 2'd0, 4'd0, 0, 5, 8'd2};
        vecs[9] = '{8'hC7, 8'hF0, 1'b0, 3'd0, 2'd0, 2'd0, 4'd0, 0, 5, 8'd2};

        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
        mem4[0] = 8'h90;
        mem4[1] = 8'hFF;
        loadMem(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        start    = 1'b0;
        start4   = 1'b0;
        alu_zero = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkReset();

        $display("[TB] main program, zero-wait and 3-wait memory");
        runMain(0);
        runMain(3);

        $display("[TB] decode vector table");
        for (int i = 0; i < 10; i++) begin
            doReset();
            loadMem(vecs[i].b0, vecs[i].b1, 8'hF0, 8'hF0);
            if (vecs[i].we)
                exp_q.push_back(we_t'{vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].we_cyc});
            applyStimulus(1'b0, 1'b0);
            waitHalt(rel);
            checkOutput($sformatf("vec%0d_halt_cyc", i), rel, vecs[i].halt_cyc);
            checkOutput($sformatf("vec%0d_halt_pc", i), {24'd0, pc}, {24'd0, vecs[i].halt_pc});
            checkOutput($sformatf("vec%0d_q_empty", i), exp_q.size(), 32'd0);
        end

        $display("[TB] conditional jump");
        runJz(1'b1);
        runJz(1'b0);

        $display("[TB] reset during second-byte fetch");
        doReset();
        loadMem(8'h81, 8'h03, 8'h16, 8'hF0);
        mem_wait = 3;
        applyStimulus(1'b0, 1'b0);
        waitCycle(7);
        checkOutput("f2_req_before_rst", {31'd0, imem_req}, 32'd1);
        checkOutput("f2_pc_before_rst", {24'd0, pc}, 32'd1);
        #1 rst = 1'b1;
        #1 checkReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("f2_q_empty", exp_q.size(), 32'd0);
        mem_wait = 0;
        exp_q.push_back(we_t'{3'b111, 2'd0, 2'd1, 4'd3, 4});
        exp_q.push_back(we_t'{3'b000, 2'd1, 2'd2, 4'd3, 7});
        applyStimulus(1'b0, 1'b0);
        waitHalt(rel);
        checkOutput("rerun_halt_cyc", rel, 32'd10);
        checkOutput("rerun_pc", {24'd0, pc}, 32'd4);
        checkOutput("rerun_q_empty", exp_q.size(), 32'd0);

        $display("[TB] unused opcodes with start held high");
        doReset();
        loadMem(8'hC3, 8'hC0, 8'hF0, 8'hF0);
        applyStimulus(1'b0, 1'b1);
        waitCycle(3);
        checkOutput("nop_fetch_addr1", {24'd0, imem_addr}, 32'd1);
        waitCycle(5);
        checkOutput("nop_fetch_addr2", {24'd0, imem_addr}, 32'd2);
        waitHalt(rel);
        checkOutput("nop_halt_cyc", rel, 32'd7);
        repeat (3) @(negedge clk);
        checkOutput("nop_halt_stays", {31'd0, halted}, 32'd1);
        checkOutput("nop_halt_pc", {24'd0, pc}, 32'd3);
        start = 1'b0;

        $display("[TB] jump and wrap with 4-bit pc");
        doReset();
        applyStimulus(1'b1, 1'b0);
        waitCycle(5);
        checkOutput("w4_pc_after_jmp", {28'd0, pc4}, 32'hF);
        checkOutput("w4_addr_after_jmp", {28'd0, addr4}, 32'hF);
        checkOutput("w4_req_after_jmp", {31'd0, req4}, 32'd1);
        waitCycle(6);
        checkOutput("w4_pc_wrap", {28'd0, pc4}, 32'd0);
        checkOutput("w4_ins_nop", {24'd0, ins_out4}, 32'd0);
        checkOutput("w4_no_we", {31'd0, reg_we4}, 32'd0);
        doReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
